// File: rtl/thread_pc_sequencer.sv
// thread_pc_sequencer
// Per-thread PC store with round-robin issue. Each issued (thread, PC) pair is
// tracked for BRANCH_LATENCY cycles; when it resolves, the branch result and IO
// readiness decide that thread's next PC. A config port can overwrite any PC.
module thread_pc_sequencer #(
  parameter int PC_WIDTH           = 10,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3,
  parameter int START_PC           = 0,
  parameter int BRANCH_LATENCY     = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  output logic                          issue_valid,
  output logic [THREAD_COUNT_WIDTH-1:0] issue_thread,
  output logic [PC_WIDTH-1:0]           issue_pc,
  input  logic                          ior,
  input  logic                          jump,
  input  logic [PC_WIDTH-1:0]           destination,
  output logic                          resolve_valid,
  output logic [THREAD_COUNT_WIDTH-1:0] resolve_thread,
  input  logic                          pc_wren,
  input  logic [THREAD_COUNT_WIDTH-1:0] pc_wr_thread,
  input  logic [PC_WIDTH-1:0]           pc_wr_data
);

  localparam int LAST_STAGE = BRANCH_LATENCY - 1;

  logic [PC_WIDTH-1:0]           pc_mem     [THREAD_COUNT];
  logic [THREAD_COUNT_WIDTH-1:0] thread_cnt;
  logic                          issue_valid_q;

  logic                          trk_valid  [BRANCH_LATENCY];
  logic [THREAD_COUNT_WIDTH-1:0] trk_thread [BRANCH_LATENCY];
  logic [PC_WIDTH-1:0]           trk_pc     [BRANCH_LATENCY];

  logic [PC_WIDTH-1:0]           res_pc;
  logic [PC_WIDTH-1:0]           next_pc;
  logic                          cfg_ok;
  logic                          res_write;

  assign issue_valid    = issue_valid_q;
  assign issue_thread   = thread_cnt;
  assign issue_pc       = pc_mem[thread_cnt];

  assign resolve_valid  = trk_valid[LAST_STAGE];
  assign resolve_thread = trk_thread[LAST_STAGE];
  assign res_pc         = trk_pc[LAST_STAGE];

  // Round-robin thread counter; holds at 0 until the first valid issue cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thread_cnt    <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      issue_valid_q <= 1'b1;
      if (issue_valid_q) begin
        if (thread_cnt == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1))
          thread_cnt <= '0;
        else
          thread_cnt <= thread_cnt + THREAD_COUNT_WIDTH'(1);
      end
    end
  end

  // Shift each issued instruction down the tracking pipe until it resolves.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BRANCH_LATENCY; i++) begin
        trk_valid[i]  <= 1'b0;
        trk_thread[i] <= '0;
        trk_pc[i]     <= '0;
      end
    end else begin
      trk_valid[0]  <= issue_valid_q;
      trk_thread[0] <= thread_cnt;
      trk_pc[0]     <= pc_mem[thread_cnt];
      for (int i = 1; i < BRANCH_LATENCY; i++) begin
        trk_valid[i]  <= trk_valid[i-1];
        trk_thread[i] <= trk_thread[i-1];
        trk_pc[i]     <= trk_pc[i-1];
      end
    end
  end

  // Next-PC selection for the resolving instruction; replay beats a taken branch,
  // and a config write to the same thread suppresses the branch update.
  always_comb begin
    next_pc   = res_pc;
    cfg_ok    = 1'b0;
    res_write = 1'b0;
    if (ior) begin
      if (jump)
        next_pc = destination;
      else
        next_pc = res_pc + PC_WIDTH'(1);
    end
    if (pc_wren && (32'(pc_wr_thread) < THREAD_COUNT))
      cfg_ok = 1'b1;
    if (resolve_valid && !(cfg_ok && (pc_wr_thread == resolve_thread)))
      res_write = 1'b1;
  end

  // PC store: branch-resolution update and config write, both at the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < THREAD_COUNT; i++)
        pc_mem[i] <= PC_WIDTH'(START_PC);
    end else begin
      if (res_write)
        pc_mem[resolve_thread] <= next_pc;
      if (cfg_ok)
        pc_mem[pc_wr_thread] <= pc_wr_data;
    end
  end

endmodule

// File: tb/tb_thread_pc_sequencer.sv
// tb_thread_pc_sequencer
// Scoreboard bench: every issued (thread, PC) is pushed into a queue with its
// issue cycle; entries are popped when they are due to resolve and drive a
// bench-side PC model that predicts future issue PCs.
module tb_thread_pc_sequencer;

  localparam int PW  = 8;
  localparam int TC  = 4;
  localparam int TCW = 2;
  localparam int LAT = 2;

  logic           clock;
  logic           reset_n;
  logic           issue_valid;
  logic [TCW-1:0] issue_thread;
  logic [PW-1:0]  issue_pc;
  logic           ior;
  logic           jump;
  logic [PW-1:0]  destination;
  logic           resolve_valid;
  logic [TCW-1:0] resolve_thread;
  logic           pc_wren;
  logic [TCW-1:0] pc_wr_thread;
  logic [PW-1:0]  pc_wr_data;

  thread_pc_sequencer #(
    .PC_WIDTH(PW), .THREAD_COUNT(TC), .THREAD_COUNT_WIDTH(TCW),
    .START_PC(0), .BRANCH_LATENCY(LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_thread(issue_thread), .issue_pc(issue_pc),
    .ior(ior), .jump(jump), .destination(destination),
    .resolve_valid(resolve_valid), .resolve_thread(resolve_thread),
    .pc_wren(pc_wren), .pc_wr_thread(pc_wr_thread), .pc_wr_data(pc_wr_data)
  );

  typedef struct {
    int             cyc;
    logic [TCW-1:0] thr;
    logic [PW-1:0]  pc;
  } entry_t;

  entry_t         sb[$];
  logic [PW-1:0]  m_pc [TC];
  logic [TCW-1:0] m_cnt;
  logic           m_valid;
  int             cyc;
  logic           exp_rv;
  logic [TCW-1:0] exp_thr;
  logic [PW-1:0]  exp_pc;
  int             compared;
  int             mismatched;
  logic [PW-1:0]  saved_pc;
  logic           found;

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < TC; i++) m_pc[i] = '0;
    m_cnt   = '0;
    m_valid = 1'b0;
    sb.delete();
    exp_rv  = 1'b0;
  endtask

  task automatic cycleCheck();
    @(negedge clock);
    exp_rv = 1'b0;
    if (sb.size() > 0 && sb[0].cyc + LAT == cyc) begin
      exp_rv  = 1'b1;
      exp_thr = sb[0].thr;
      exp_pc  = sb[0].pc;
    end
    checkOutput("issue_valid", 32'(issue_valid), 32'(m_valid));
    if (m_valid) begin
      checkOutput("issue_thread", 32'(issue_thread), 32'(m_cnt));
      checkOutput("issue_pc", 32'(issue_pc), 32'(m_pc[m_cnt]));
    end
    checkOutput("resolve_valid", 32'(resolve_valid), 32'(exp_rv));
    if (exp_rv)
      checkOutput("resolve_thread", 32'(resolve_thread), 32'(exp_thr));
  endtask

  task automatic applyStimulus(input logic i_ior, input logic i_jump,
                               input logic [PW-1:0] i_dest, input logic i_wren,
                               input logic [TCW-1:0] i_wthr, input logic [PW-1:0] i_wdata);
    logic [PW-1:0] ipc;
    ior          = i_ior;
    jump         = i_jump;
    destination  = i_dest;
    pc_wren      = i_wren;
    pc_wr_thread = i_wthr;
    pc_wr_data   = i_wdata;
    ipc = m_pc[m_cnt];
    if (exp_rv) begin
      void'(sb.pop_front());
      if (!(i_wren && i_wthr == exp_thr)) begin
        if (!i_ior)      m_pc[exp_thr] = exp_pc;
        else if (i_jump) m_pc[exp_thr] = i_dest;
        else             m_pc[exp_thr] = exp_pc + 8'd1;
      end
    end
    if (i_wren) m_pc[i_wthr] = i_wdata;
    if (m_valid) begin
      sb.push_back('{cyc: cyc, thr: m_cnt, pc: ipc});
      m_cnt = (m_cnt == TCW'(TC - 1)) ? '0 : m_cnt + 2'd1;
    end
    m_valid = 1'b1;
    cyc++;
  endtask

  task automatic idleStep();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic runUntilResolve(input logic [TCW-1:0] thr);
    found = 1'b0;
    for (int n = 0; n < 16 && !found; n++) begin
      cycleCheck();
      if (exp_rv && exp_thr == thr) found = 1'b1;
      else idleStep();
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_resolve: thread %0d never resolved", thr);
      cycleCheck();
    end
  endtask

  task automatic runUntilIssue(input logic [TCW-1:0] thr);
    found = 1'b0;
    for (int n = 0; n < 16 && !found; n++) begin
      cycleCheck();
      if (m_valid && m_cnt == thr) found = 1'b1;
      else idleStep();
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_issue: thread %0d never issued", thr);
      cycleCheck();
    end
  endtask

  task automatic runPlanSequence();
    for (int k = 0; k < 12; k++) begin
      cycleCheck();
      checkOutput("seq_thread", 32'(issue_thread), 32'(k % 4));
      checkOutput("seq_pc", 32'(issue_pc), 32'(k / 4));
      if (k < 2) checkOutput("seq_no_resolve", 32'(resolve_valid), 32'd0);
      if (k == 2) begin
        checkOutput("first_resolve_valid", 32'(resolve_valid), 32'd1);
        checkOutput("first_resolve_thread", 32'(resolve_thread), 32'd0);
      end
      idleStep();
    end
  endtask

  // Directed scenarios walking through normal flow, branches, replay, config and reset.
  initial begin
    compared = 0; mismatched = 0; cyc = 0;
    reset_n = 1'b0;
    ior = 1'b1; jump = 1'b0; destination = '0;
    pc_wren = 1'b0; pc_wr_thread = '0; pc_wr_data = '0;
    modelReset();

    cycleCheck();
    checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("rst_resolve_valid", 32'(resolve_valid), 32'd0);
    checkOutput("rst_resolve_thread", 32'(resolve_thread), 32'd0);
    checkOutput("rst_issue_thread", 32'(issue_thread), 32'd0);
    checkOutput("rst_issue_pc", 32'(issue_pc), 32'd0);
    reset_n = 1'b1;
    idleStep();

    $display("[TB] normal round-robin flow");
    runPlanSequence();

    $display("[TB] taken branch on thread 1");
    runUntilResolve(2'd1);
    applyStimulus(1'b1, 1'b1, 8'h40, 1'b0, '0, '0);
    runUntilIssue(2'd1);
    checkOutput("jump_dest", 32'(issue_pc), 32'h40);
    idleStep();

    $display("[TB] replay on thread 2");
    runUntilResolve(2'd2);
    saved_pc = exp_pc;
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, '0, '0);
    runUntilIssue(2'd2);
    checkOutput("replay_pc", 32'(issue_pc), 32'(saved_pc));
    idleStep();

    $display("[TB] config write to thread 3 and wrap");
    runUntilIssue(2'd2);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 2'd3, 8'hFF);
    runUntilIssue(2'd3);
    checkOutput("cfg_pc", 32'(issue_pc), 32'hFF);
    idleStep();
    runUntilIssue(2'd3);
    checkOutput("wrap_pc", 32'(issue_pc), 32'h00);
    idleStep();

    $display("[TB] config write colliding with thread 0 resolve");
    runUntilResolve(2'd0);
    applyStimulus(1'b1, 1'b1, 8'h30, 1'b1, 2'd0, 8'h20);
    runUntilIssue(2'd0);
    checkOutput("cfg_wins", 32'(issue_pc), 32'h20);
    idleStep();

    $display("[TB] reset mid-run");
    runUntilResolve(2'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("midrst_resolve_valid", 32'(resolve_valid), 32'd0);
    modelReset();
    pc_wren = 1'b1; pc_wr_thread = 2'd1; pc_wr_data = 8'h55;
    cycleCheck();
    reset_n = 1'b1;
    idleStep();
    runPlanSequence();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
